// File: rtl/gemma_acc_pkg.sv
// Shared types for the GEMM tile scheduler: FSM state encoding, default tile size
// and the job descriptor handed to the tile engine.
package gemma_acc_pkg;

    localparam int DEF_TILE_BYTES = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [63:0] addr_a;
        logic [63:0] addr_b;
        logic [63:0] addr_c;
        logic        k_first;
        logic        k_last;
    } tile_job_t;

endpackage

// File: rtl/gemma_tile_addr_gen.sv
// Tile index walker (m outer, n, k inner) with incrementally updated A/B/C tile
// addresses; only adds of TILE_BYTES and a shifted B row stride, no multipliers.
module gemma_tile_addr_gen
    import gemma_acc_pkg::*;
#(
    parameter int TILE_BYTES = DEF_TILE_BYTES,
    parameter int CNT_W      = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [63:0]      base_a,
    input  logic [63:0]      base_b,
    input  logic [63:0]      base_c,
    input  logic [CNT_W-1:0] m_tiles,
    input  logic [CNT_W-1:0] n_tiles,
    input  logic [CNT_W-1:0] k_tiles,
    output tile_job_t        job,
    output logic             last_job
);

    localparam int          TILE_SH  = $clog2(TILE_BYTES);
    localparam logic [63:0] TILE_INC = 64'(TILE_BYTES);

    logic [CNT_W-1:0] m_max, n_max, k_max;
    logic [CNT_W-1:0] m_idx, n_idx, k_idx;
    logic [63:0]      addr_a, addr_b, addr_c;
    logic [63:0]      a_row, b_col, b_base, b_stride;
    logic             k_first, k_last;
    logic             k_wrap, n_wrap;

    assign k_wrap   = (k_idx == k_max);
    assign n_wrap   = (n_idx == n_max);
    assign last_job = (m_idx == m_max) && n_wrap && k_wrap;

    assign job = '{addr_a: addr_a, addr_b: addr_b, addr_c: addr_c,
                   k_first: k_first, k_last: k_last};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_max    <= '0;
            n_max    <= '0;
            k_max    <= '0;
            m_idx    <= '0;
            n_idx    <= '0;
            k_idx    <= '0;
            addr_a   <= '0;
            addr_b   <= '0;
            addr_c   <= '0;
            a_row    <= '0;
            b_col    <= '0;
            b_base   <= '0;
            b_stride <= '0;
            k_first  <= 1'b0;
            k_last   <= 1'b0;
        end else if (load) begin
            m_max    <= m_tiles - CNT_W'(1);
            n_max    <= n_tiles - CNT_W'(1);
            k_max    <= k_tiles - CNT_W'(1);
            m_idx    <= '0;
            n_idx    <= '0;
            k_idx    <= '0;
            addr_a   <= base_a;
            addr_b   <= base_b;
            addr_c   <= base_c;
            a_row    <= base_a;
            b_col    <= base_b;
            b_base   <= base_b;
            b_stride <= 64'(n_tiles) << TILE_SH;
            k_first  <= 1'b1;
            k_last   <= (k_tiles == CNT_W'(1));
        end else if (advance) begin
            if (!k_wrap) begin
                k_idx   <= k_idx + CNT_W'(1);
                addr_a  <= addr_a + TILE_INC;
                addr_b  <= addr_b + b_stride;
                k_first <= 1'b0;
                k_last  <= ((k_idx + CNT_W'(1)) == k_max);
            end else begin
                k_idx   <= '0;
                k_first <= 1'b1;
                k_last  <= (k_max == '0);
                addr_c  <= addr_c + TILE_INC;
                if (!n_wrap) begin
                    // Same A row restarts; B moves one column right.
                    n_idx  <= n_idx + CNT_W'(1);
                    addr_a <= a_row;
                    addr_b <= b_col + TILE_INC;
                    b_col  <= b_col + TILE_INC;
                end else begin
                    // Next A row begins right after the last tile of this one.
                    n_idx  <= '0;
                    m_idx  <= m_idx + CNT_W'(1);
                    addr_a <= addr_a + TILE_INC;
                    a_row  <= addr_a + TILE_INC;
                    addr_b <= b_base;
                    b_col  <= b_base;
                end
            end
        end
    end

endmodule

// File: rtl/gemma_tile_scheduler.sv
// Sequences the single-tile GEMM engine over an M x N x K tiled multiply.
// Optional GEMMA_SCHED_PERF_EN adds busy-cycle and stall-cycle counters.
//
//  state | meaning
//  IDLE  | waiting for cfg_start
//  ISSUE | offering jobs while credits remain
//  DRAIN | all jobs issued (or aborted), waiting for outstanding completions
//  DONE  | one-cycle completion pulse
module gemma_tile_scheduler
    import gemma_acc_pkg::*;
#(
    parameter int TILE_BYTES      = DEF_TILE_BYTES,
    parameter int CNT_W           = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [63:0]      cfg_base_a,
    input  logic [63:0]      cfg_base_b,
    input  logic [63:0]      cfg_base_c,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    output logic             job_valid,
    input  logic             job_ready,
    output logic [63:0]      job_addr_a,
    output logic [63:0]      job_addr_b,
    output logic [63:0]      job_addr_c,
    output logic             job_k_first,
    output logic             job_k_last,
    input  logic             job_done,
    output logic             busy,
    output logic             done,
    output logic             err_cfg,
    output logic             aborted
`ifdef GEMMA_SCHED_PERF_EN
   ,output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall
`endif
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    sched_state_t     state_q, state_d;
    logic [OUT_W-1:0] outs_q, outs_d;
    logic             hs, done_ok, cfg_zero, start_ok, load, last_job;
    tile_job_t        job;

    assign cfg_zero  = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);
    assign start_ok  = (state_q == ST_IDLE) && cfg_start;
    assign load      = start_ok && !cfg_zero;
    assign job_valid = (state_q == ST_ISSUE) && (outs_q < OUT_MAX);
    assign hs        = job_valid && job_ready;
    assign done_ok   = job_done && (outs_q != '0);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    assign job_addr_a  = job.addr_a;
    assign job_addr_b  = job.addr_b;
    assign job_addr_c  = job.addr_c;
    assign job_k_first = job.k_first;
    assign job_k_last  = job.k_last;

    gemma_tile_addr_gen #(
        .TILE_BYTES (TILE_BYTES),
        .CNT_W      (CNT_W)
    ) u_addr_gen (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .load     (load),
        .advance  (hs && !last_job),
        .base_a   (cfg_base_a),
        .base_b   (cfg_base_b),
        .base_c   (cfg_base_c),
        .m_tiles  (cfg_m_tiles),
        .n_tiles  (cfg_n_tiles),
        .k_tiles  (cfg_k_tiles),
        .job      (job),
        .last_job (last_job)
    );

    always_comb begin
        outs_d = outs_q;
        if (hs && !done_ok) begin
            outs_d = outs_q + OUT_W'(1);
        end else if (!hs && done_ok) begin
            outs_d = outs_q - OUT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cfg_start) state_d = cfg_zero ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (cfg_abort || (hs && last_job)) state_d = ST_DRAIN;
            ST_DRAIN: if (outs_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            outs_q  <= '0;
            err_cfg <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
            if (start_ok) begin
                err_cfg <= cfg_zero;
                aborted <= 1'b0;
            end else if (cfg_abort && (state_q == ST_ISSUE)) begin
                aborted <= 1'b1;
            end
        end
    end

`ifdef GEMMA_SCHED_PERF_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 32'd1;
            if (job_valid && !job_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gemma_tile_scheduler.sv
// Directed self-checking bench for gemma_tile_scheduler (default parameters).
module tb_gemma_tile_scheduler;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        cfg_start, cfg_abort;
    logic [63:0] cfg_base_a, cfg_base_b, cfg_base_c;
    logic [15:0] cfg_m_tiles, cfg_n_tiles, cfg_k_tiles;
    logic        job_valid, job_ready, job_done;
    logic [63:0] job_addr_a, job_addr_b, job_addr_c;
    logic        job_k_first, job_k_last;
    logic        busy, done, err_cfg, aborted;
`ifdef GEMMA_SCHED_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    int n_pass  = 0;
    int n_total = 0;

    gemma_tile_scheduler dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .cfg_base_a  (cfg_base_a),
        .cfg_base_b  (cfg_base_b),
        .cfg_base_c  (cfg_base_c),
        .cfg_m_tiles (cfg_m_tiles),
        .cfg_n_tiles (cfg_n_tiles),
        .cfg_k_tiles (cfg_k_tiles),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_addr_a  (job_addr_a),
        .job_addr_b  (job_addr_b),
        .job_addr_c  (job_addr_c),
        .job_k_first (job_k_first),
        .job_k_last  (job_k_last),
        .job_done    (job_done),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg),
        .aborted     (aborted)
`ifdef GEMMA_SCHED_PERF_EN
       ,.perf_cycles (perf_cycles),
        .perf_stall  (perf_stall)
`endif
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic set_cfg(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           input logic [15:0] m, input logic [15:0] n, input logic [15:0] k);
        cfg_base_a  = a;
        cfg_base_b  = b;
        cfg_base_c  = c;
        cfg_m_tiles = m;
        cfg_n_tiles = n;
        cfg_k_tiles = k;
    endtask

    task automatic test_reset();
        logic [4:0] ctl;
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ctl = {job_valid, busy, done, err_cfg, aborted};
        n_total++;
        if (ctl !== 5'b0) $display("FAIL reset_ctl: got %b expected %b", ctl, 5'b0);
        else n_pass++;
        n_total++;
        if ({job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last} !== 194'b0)
            $display("FAIL reset_fields: got %h expected 0",
                     {job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last});
        else n_pass++;
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_cfg(64'h1000, 64'h2000, 64'h3000, 16'd1, 16'd1, 16'd1);
        job_ready = 1'b1;
        job_done = 1'b1;              // stray completion while idle must be ignored
        tick();
        job_done = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_total++;
        if ({job_valid, busy} !== 2'b11) $display("FAIL single_valid: got %b expected 11", {job_valid, busy});
        else n_pass++;
        n_total++;
        if ({job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last} !==
            {64'h1000, 64'h2000, 64'h3000, 1'b1, 1'b1})
            $display("FAIL single_fields: got %h %h %h %b%b expected 1000 2000 3000 11",
                     job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last);
        else n_pass++;
        tick();
        n_total++;
        if ({job_valid, done} !== 2'b00) $display("FAIL single_drain: got %b expected 00", {job_valid, done});
        else n_pass++;
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        n_total++;
        if (done !== 1'b1) $display("FAIL single_done: got %b expected 1", done);
        else n_pass++;
        tick();
        n_total++;
        if ({done, busy, err_cfg, aborted} !== 4'b0)
            $display("FAIL single_idle: got %b expected 0000", {done, busy, err_cfg, aborted});
        else n_pass++;
    endtask

    task automatic test_seq_2x2x2();
        logic [63:0] exp_a [8] = '{64'h0, 64'h100, 64'h0, 64'h100, 64'h200, 64'h300, 64'h200, 64'h300};
        logic [63:0] exp_b [8] = '{64'h0, 64'h200, 64'h100, 64'h300, 64'h0, 64'h200, 64'h100, 64'h300};
        logic [63:0] exp_c [8] = '{64'h0, 64'h0, 64'h100, 64'h100, 64'h200, 64'h200, 64'h300, 64'h300};
        int  issued = 0, retired = 0, got = 0, first = -1, last = -1;
        bit  seen = 1'b0;
        logic kf, kl;
        set_cfg(64'h0, 64'h0, 64'h0, 16'd2, 16'd2, 16'd2);
        job_ready = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                job_done = (issued > retired);
                if (job_done) retired++;
                if (job_valid) begin
                    if (got < 8) begin
                        kf = (got % 2 == 0);
                        kl = (got % 2 == 1);
                        n_total++;
                        if ({job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last} !==
                            {exp_a[got], exp_b[got], exp_c[got], kf, kl})
                            $display("FAIL seq_job%0d: got %h %h %h %b%b expected %h %h %h %b%b", got,
                                     job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last,
                                     exp_a[got], exp_b[got], exp_c[got], kf, kl);
                        else n_pass++;
                    end
                    if (first < 0) first = cyc;
                    last = cyc;
                    got++;
                    issued++;
                end
                tick();
            end
        end
        job_done = 1'b0;
        n_total++;
        if (seen !== 1'b1) $display("FAIL seq_done: got %b expected 1", seen);
        else n_pass++;
        n_total++;
        if (got != 8) $display("FAIL seq_count: got %0d expected 8", got);
        else n_pass++;
        n_total++;
        if (last - first != 7) $display("FAIL seq_b2b: got span %0d expected 7", last - first);
        else n_pass++;
        tick();
    endtask

    task automatic test_credit_limit();
        int hs = 0;
        bit seen;
        set_cfg(64'h0, 64'h0, 64'h0, 16'd4, 16'd4, 16'd4);
        job_ready = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (job_valid) hs++;
            tick();
        end
        n_total++;
        if (hs != 2) $display("FAIL credit_hs: got %0d expected 2", hs);
        else n_pass++;
        n_total++;
        if (job_valid !== 1'b0) $display("FAIL credit_valid: got %b expected 0", job_valid);
        else n_pass++;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        job_done = 1'b1;
        tick();
        tick();
        job_done = 1'b0;
        wait_done(5, seen);
        n_total++;
        if (seen !== 1'b1) $display("FAIL credit_done: got %b expected 1", seen);
        else n_pass++;
        tick();
    endtask

    task automatic test_zero_cfg();
        bit seen = 1'b0, vseen = 1'b0;
        set_cfg(64'h0, 64'h0, 64'h0, 16'd1, 16'd1, 16'd0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (job_valid) vseen = 1'b1;
            if (done) seen = 1'b1;
            else tick();
        end
        n_total++;
        if ({seen, vseen} !== 2'b10) $display("FAIL zero_cfg_flow: got done=%b valid=%b expected 1 0", seen, vseen);
        else n_pass++;
        n_total++;
        if (err_cfg !== 1'b1) $display("FAIL zero_cfg_err: got %b expected 1", err_cfg);
        else n_pass++;
        tick();
        n_total++;
        if ({busy, err_cfg} !== 2'b01) $display("FAIL zero_cfg_sticky: got %b expected 01", {busy, err_cfg});
        else n_pass++;
    endtask

    task automatic test_stall();
        bit stable = 1'b1;
        bit seen;
        set_cfg(64'h4000, 64'h5000, 64'h6000, 16'd1, 16'd1, 16'd2);
        job_ready = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_total++;
        if (err_cfg !== 1'b0) $display("FAIL stall_err_clear: got %b expected 0", err_cfg);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if ({job_valid, job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last} !==
                {1'b1, 64'h4000, 64'h5000, 64'h6000, 1'b1, 1'b0}) stable = 1'b0;
            tick();
        end
        n_total++;
        if (stable !== 1'b1) $display("FAIL stall_hold: got %b expected 1", stable);
        else n_pass++;
        job_ready = 1'b1;
        tick();
        n_total++;
        if ({job_valid, job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last} !==
            {1'b1, 64'h4100, 64'h5100, 64'h6000, 1'b0, 1'b1})
            $display("FAIL stall_job2: got %b %h %h %h %b%b expected 1 4100 5100 6000 01", job_valid,
                     job_addr_a, job_addr_b, job_addr_c, job_k_first, job_k_last);
        else n_pass++;
        tick();
        job_ready = 1'b0;
`ifdef GEMMA_SCHED_PERF_EN
        n_total++;
        if (perf_stall !== 32'd5) $display("FAIL perf_stall: got %0d expected 5", perf_stall);
        else n_pass++;
        n_total++;
        if (perf_cycles !== 32'd7) $display("FAIL perf_cycles: got %0d expected 7", perf_cycles);
        else n_pass++;
`endif
        job_done = 1'b1;
        tick();
        tick();
        job_done = 1'b0;
        wait_done(5, seen);
        n_total++;
        if (seen !== 1'b1) $display("FAIL stall_done: got %b expected 1", seen);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        int hs = 0;
        bit bad = 1'b0;
        set_cfg(64'h8000, 64'h9000, 64'hA000, 16'd2, 16'd2, 16'd2);
        job_ready = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (job_valid) hs++;
            tick();
        end
        job_done = 1'b1;
        if (job_valid) hs++;
        tick();
        job_done = 1'b0;
        if (job_valid) hs++;
        tick();
        n_total++;
        if (hs != 3) $display("FAIL abort_hs: got %0d expected 3", hs);
        else n_pass++;
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        n_total++;
        if ({job_valid, busy, aborted} !== 3'b011)
            $display("FAIL abort_state: got %b expected 011", {job_valid, busy, aborted});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (job_valid || done) bad = 1'b1;
            tick();
        end
        n_total++;
        if (bad !== 1'b0) $display("FAIL abort_quiet: got %b expected 0", bad);
        else n_pass++;
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        n_total++;
        if (done !== 1'b0) $display("FAIL abort_early_done: got %b expected 0", done);
        else n_pass++;
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        n_total++;
        if (done !== 1'b1) $display("FAIL abort_done: got %b expected 1", done);
        else n_pass++;
        tick();
        n_total++;
        if ({busy, aborted} !== 2'b01) $display("FAIL abort_sticky: got %b expected 01", {busy, aborted});
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        set_cfg(64'h8000, 64'h9000, 64'hA000, 16'd2, 16'd2, 16'd2);
        job_ready = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_total++;
        if ({job_valid, aborted} !== 2'b10) $display("FAIL restart_clear: got %b expected 10", {job_valid, aborted});
        else n_pass++;
        tick();
        ap_rst_n = 1'b0;
        #1;
        n_total++;
        if ({job_valid, busy, done, err_cfg, aborted} !== 5'b0)
            $display("FAIL midrst_ctl: got %b expected 00000", {job_valid, busy, done, err_cfg, aborted});
        else n_pass++;
        n_total++;
        if ({job_addr_a, job_addr_c} !== 128'b0)
            $display("FAIL midrst_addr: got %h %h expected 0 0", job_addr_a, job_addr_c);
        else n_pass++;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();
        n_total++;
        if ({job_valid, busy} !== 2'b00) $display("FAIL midrst_idle: got %b expected 00", {job_valid, busy});
        else n_pass++;
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        job_ready = 1'b0;
        job_done  = 1'b0;
        set_cfg(64'h0, 64'h0, 64'h0, 16'd0, 16'd0, 16'd0);
        test_reset();
        test_single();
        test_seq_2x2x2();
        test_credit_limit();
        test_zero_cfg();
        test_stall();
        test_abort();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
